// File: rtl/rx_buff_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_buff_wr_ctrl_if
// Description : Frame-beat stream, buffer write port and commit signalling
//               between the MAC receive path, the RX buffer and its reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_buff_wr_ctrl_if #(
   parameter int AW = 10,
   parameter int DW = 64
);
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_last;
   logic [3:0]    in_bytes;
   logic          in_bad;
   logic          in_ready;
   logic [AW-1:0] a;
   logic [DW-1:0] d;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] commit_addr;
   logic          frame_done;
   logic [31:0]   drop_cnt;

   modport slave (
      input  in_data, in_valid, in_last, in_bytes, in_bad, rd_addr,
      output in_ready, a, d, commit_addr, frame_done, drop_cnt
   );

   modport master (
      output in_data, in_valid, in_last, in_bytes, in_bad, rd_addr,
      input  in_ready, a, d, commit_addr, frame_done, drop_cnt
   );
endinterface
`default_nettype wire

// File: rtl/rx_buff_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rx_buff_wr_ctrl
// Description : Write-side sequencer of the RX frame buffer: stores each frame
//               as a length header plus data words, drops bad/overflowing
//               frames and publishes a committed write pointer to the reader.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_buff_wr_ctrl #(
   parameter int AW = 10,
   parameter int DW = 64
) (
   input  logic             clk,
   input  logic             reset,
   rx_buff_wr_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_HDR  = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cmt_ptr_q, cmt_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [15:0]   words_q, words_d;
   logic [3:0]    bytes_q, bytes_d;
   logic          in_ready_q, in_ready_d;
   logic [AW-1:0] a_q, a_d;
   logic [DW-1:0] d_q, d_d;
   logic          pend1_q, pend1_d;
   logic [AW-1:0] pend1_addr_q, pend1_addr_d;
   logic          pend2_q, pend2_d;
   logic [AW-1:0] pend2_addr_q, pend2_addr_d;
   logic [AW-1:0] commit_addr_q, commit_addr_d;
   logic          frame_done_q, frame_done_d;
   logic [31:0]   drop_cnt_q, drop_cnt_d;

   logic          accept;
   logic          drop_inc;
   logic [AW-1:0] free_cmt;
   logic [AW-1:0] free_wr;
   logic [15:0]   hdr_len;

   assign accept   = bus.in_valid & in_ready_q;
   assign free_cmt = bus.rd_addr - cmt_ptr_q - AW'(1);
   assign free_wr  = bus.rd_addr - wr_ptr_q - AW'(1);
   assign hdr_len  = ((words_q - 16'd1) << 3) + {12'd0, bytes_q};

   always_comb begin
      state_d   = state_q;
      cmt_ptr_d = cmt_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      words_d   = words_q;
      bytes_d   = bytes_q;
      a_d       = cmt_ptr_q;
      d_d       = '0;
      drop_inc  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (free_cmt < AW'(2)) begin
                  drop_inc = 1'b1;
                  if (!bus.in_last) state_d = S_DROP;
               end else if (bus.in_last && bus.in_bad) begin
                  drop_inc = 1'b1;
               end else begin
                  a_d      = cmt_ptr_q + AW'(1);
                  d_d      = bus.in_data;
                  wr_ptr_d = cmt_ptr_q + AW'(2);
                  words_d  = 16'd1;
                  if (bus.in_last) begin
                     bytes_d = bus.in_bytes;
                     state_d = S_HDR;
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
         end

         S_DATA: begin
            a_d = wr_ptr_q;
            if (accept) begin
               if (free_wr == '0 || (bus.in_last && bus.in_bad)) begin
                  // Discarded beat: park on the header slot, rewind the frame.
                  drop_inc = 1'b1;
                  a_d      = cmt_ptr_q;
                  wr_ptr_d = cmt_ptr_q + AW'(1);
                  state_d  = bus.in_last ? S_IDLE : S_DROP;
               end else begin
                  d_d      = bus.in_data;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  words_d  = words_q + 16'd1;
                  if (bus.in_last) begin
                     bytes_d = bus.in_bytes;
                     state_d = S_HDR;
                  end
               end
            end
         end

         S_HDR: begin
            d_d       = {{(DW-16){1'b0}}, hdr_len};
            cmt_ptr_d = wr_ptr_q;
            // Keep wr_ptr one past the header slot while idle.
            wr_ptr_d  = wr_ptr_q + AW'(1);
            state_d   = S_IDLE;
         end

         default: begin
            if (accept && bus.in_last) state_d = S_IDLE;
         end
      endcase

      in_ready_d = (state_d != S_HDR);

      // Two-stage delay so the header is in memory before the reader sees it.
      pend1_d       = (state_q == S_HDR);
      pend1_addr_d  = wr_ptr_q;
      pend2_d       = pend1_q;
      pend2_addr_d  = pend1_addr_q;
      commit_addr_d = pend2_q ? pend2_addr_q : commit_addr_q;
      frame_done_d  = pend2_q;

      drop_cnt_d = (drop_inc && drop_cnt_q != 32'hFFFF_FFFF) ? drop_cnt_q + 32'd1
                                                             : drop_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cmt_ptr_q     <= '0;
         wr_ptr_q      <= AW'(1);
         words_q       <= '0;
         bytes_q       <= '0;
         in_ready_q    <= 1'b1;
         a_q           <= '0;
         d_q           <= '0;
         pend1_q       <= 1'b0;
         pend1_addr_q  <= '0;
         pend2_q       <= 1'b0;
         pend2_addr_q  <= '0;
         commit_addr_q <= '0;
         frame_done_q  <= 1'b0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         cmt_ptr_q     <= cmt_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         words_q       <= words_d;
         bytes_q       <= bytes_d;
         in_ready_q    <= in_ready_d;
         a_q           <= a_d;
         d_q           <= d_d;
         pend1_q       <= pend1_d;
         pend1_addr_q  <= pend1_addr_d;
         pend2_q       <= pend2_d;
         pend2_addr_q  <= pend2_addr_d;
         commit_addr_q <= commit_addr_d;
         frame_done_q  <= frame_done_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.a           = a_q;
   assign bus.d           = d_q;
   assign bus.commit_addr = commit_addr_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.drop_cnt    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_buff_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_buff_wr_ctrl
// Description : Self-checking bench: cycle vectors plus a frame scoreboard
//               checked against a shadow copy of the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_buff_wr_ctrl;
   localparam int AW = 4;
   localparam int DW = 64;
   localparam int NV = 14;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rx_buff_wr_ctrl_if #(.AW(AW), .DW(DW)) bus ();
   rx_buff_wr_ctrl #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(rst), .bus(bus));

   typedef struct {
      logic        rst;
      logic        v;
      logic        l;
      logic [3:0]  by;
      logic [63:0] dat;
      logic        rdy;
      logic [3:0]  a;
      logic [63:0] d;
      logic [3:0]  c;
      logic        fd;
      logic [31:0] drop;
   } vec_t;

   typedef struct {
      logic [3:0]  hdr;
      logic [15:0] len;
      int          n;
      logic [63:0] base;
      logic [3:0]  commit;
   } exp_t;

   int          total = 0;
   int          bad   = 0;
   vec_t        vt[NV];
   exp_t        sbq[$];
   logic [63:0] mem[16];
   logic [3:0]  m_cmt;
   int          exp_drop;
   logic        sb_on = 1'b0;
   logic [3:0]  prev_commit = 4'd0;
   int          low_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Shadow buffer and frame scoreboard, evaluated away from the active edge.
   always @(negedge clk) begin
      if (sb_on && !rst) begin
         if (bus.in_ready === 1'b0) low_cnt <= low_cnt + 1;
         if (bus.frame_done === 1'b1) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_frame_done: got commit %h expected no commit", bus.commit_addr);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("commit_addr", 64'(bus.commit_addr), 64'(e.commit));
               check("header_word", mem[e.hdr], {48'd0, e.len});
               for (int i = 0; i < e.n; i++) begin
                  logic [3:0] idx;
                  idx = e.hdr + 4'(i + 1);
                  check("data_word", mem[idx], e.base + 64'(i));
               end
            end
         end else begin
            check("commit_hold", 64'(bus.commit_addr), 64'(prev_commit));
         end
      end
      prev_commit <= bus.commit_addr;
      mem[bus.a]  <= bus.d;
   end

   task automatic reset_dut();
      sb_on = 1'b0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_bad   = 1'b0;
      bus.in_bytes = 4'd0;
      bus.in_data  = '0;
      bus.rd_addr  = 4'd0;
      sbq.delete();
      m_cmt = 4'd0;
      exp_drop = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      sb_on = 1'b1;
   endtask

   task automatic put_beat(input logic [63:0] dat, input logic l, input logic [3:0] by, input logic bd);
      int guard;
      guard = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = dat;
      bus.in_last  = l;
      bus.in_bytes = by;
      bus.in_bad   = bd;
      while (bus.in_ready !== 1'b1 && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 20) begin
         total++;
         bad++;
         $display("FAIL in_ready_timeout: got in_ready %b expected 1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_bad   = 1'b0;
   endtask

   task automatic send_frame(input int n, input logic [3:0] by, input logic bd,
                             input logic ok, input logic [7:0] id);
      exp_t        e;
      logic [63:0] base;
      base = 64'hA500_0000_0000_0000 | (64'(id) << 16);
      if (ok) begin
         e.hdr    = m_cmt;
         e.len    = 16'(8 * (n - 1)) + {12'd0, by};
         e.n      = n;
         e.base   = base;
         e.commit = m_cmt + 4'(n + 1);
         sbq.push_back(e);
         m_cmt    = e.commit;
      end else begin
         exp_drop++;
      end
      for (int i = 0; i < n; i++)
         put_beat(base + 64'(i), (i == n - 1), by, bd && (i == n - 1));
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while (sbq.size() != 0 && g < 60) begin
         @(posedge clk);
         #1;
         g++;
      end
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL commit_timeout: got %0d frames pending expected 0", sbq.size());
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      int lc0;
      #200000;
      $display("FAIL watchdog: got no end expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lc0;
      //         rst   v     l     by     dat                       rdy   a     d                         c     fd    drop
      vt[0]  = '{1'b0, 1'b1, 1'b1, 4'd5, 64'h1111_2222_3333_4444, 1'b1, 4'd0, 64'd0,                   4'd0, 1'b0, 32'd0};
      vt[1]  = '{1'b0, 1'b0, 1'b0, 4'd0, 64'd0,                   1'b0, 4'd1, 64'h1111_2222_3333_4444, 4'd0, 1'b0, 32'd0};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 4'd0, 64'd0,                   1'b1, 4'd0, 64'd5,                   4'd0, 1'b0, 32'd0};
      vt[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, 64'd0,                   1'b1, 4'd2, 64'd0,                   4'd0, 1'b0, 32'd0};
      vt[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, 64'd0,                   1'b1, 4'd2, 64'd0,                   4'd2, 1'b1, 32'd0};
      vt[5]  = '{1'b0, 1'b1, 1'b0, 4'd8, 64'h1111_2222_3333_5555, 1'b1, 4'd2, 64'd0,                   4'd2, 1'b0, 32'd0};
      vt[6]  = '{1'b0, 1'b1, 1'b0, 4'd8, 64'h1111_2222_3333_6666, 1'b1, 4'd3, 64'h1111_2222_3333_5555, 4'd2, 1'b0, 32'd0};
      vt[7]  = '{1'b1, 1'b0, 1'b0, 4'd0, 64'd0,                   1'b1, 4'd4, 64'h1111_2222_3333_6666, 4'd2, 1'b0, 32'd0};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 4'd0, 64'd0,                   1'b1, 4'd0, 64'd0,                   4'd0, 1'b0, 32'd0};
      vt[9]  = '{1'b0, 1'b1, 1'b1, 4'd8, 64'h1111_2222_3333_7777, 1'b1, 4'd0, 64'd0,                   4'd0, 1'b0, 32'd0};
      vt[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 64'd0,                   1'b0, 4'd1, 64'h1111_2222_3333_7777, 4'd0, 1'b0, 32'd0};
      vt[11] = '{1'b0, 1'b0, 1'b0, 4'd0, 64'd0,                   1'b1, 4'd0, 64'd8,                   4'd0, 1'b0, 32'd0};
      vt[12] = '{1'b0, 1'b0, 1'b0, 4'd0, 64'd0,                   1'b1, 4'd2, 64'd0,                   4'd0, 1'b0, 32'd0};
      vt[13] = '{1'b0, 1'b0, 1'b0, 4'd0, 64'd0,                   1'b1, 4'd2, 64'd0,                   4'd2, 1'b1, 32'd0};

      // Cycle-exact vectors: single-beat frame, partial frame cut by reset.
      reset_dut();
      sb_on = 1'b0;
      for (int i = 0; i < NV; i++) begin
         rst          = vt[i].rst;
         bus.in_valid = vt[i].v;
         bus.in_last  = vt[i].l;
         bus.in_bytes = vt[i].by;
         bus.in_data  = vt[i].dat;
         bus.in_bad   = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'(vt[i].rdy));
         check($sformatf("vec%0d_a", i), 64'(bus.a), 64'(vt[i].a));
         check($sformatf("vec%0d_d", i), bus.d, vt[i].d);
         check($sformatf("vec%0d_commit", i), 64'(bus.commit_addr), 64'(vt[i].c));
         check($sformatf("vec%0d_frame_done", i), 64'(bus.frame_done), 64'(vt[i].fd));
         check($sformatf("vec%0d_drop_cnt", i), 64'(bus.drop_cnt), 64'(vt[i].drop));
         @(posedge clk);
         #1;
      end

      // 3-beat frame, full last beat.
      reset_dut();
      send_frame(3, 4'd8, 1'b0, 1'b1, 8'd1);
      wait_done();
      check("three_beat_commit", 64'(bus.commit_addr), 64'd4);

      // Back-to-back 2-beat frames: one bubble each.
      reset_dut();
      lc0 = low_cnt;
      send_frame(2, 4'd3, 1'b0, 1'b1, 8'd2);
      send_frame(2, 4'd8, 1'b0, 1'b1, 8'd3);
      wait_done();
      check("b2b_bubbles", 64'(low_cnt - lc0), 64'd2);
      check("b2b_commit", 64'(bus.commit_addr), 64'd6);

      // Overflow with reader parked at 0: 14 data words fit, the 15th overflows.
      reset_dut();
      send_frame(16, 4'd8, 1'b0, 1'b0, 8'd4);
      wait_done();
      check("ovf_drop_cnt", 64'(bus.drop_cnt), 64'(exp_drop));
      check("ovf_commit", 64'(bus.commit_addr), 64'd0);
      bus.rd_addr = 4'd15;
      send_frame(3, 4'd8, 1'b0, 1'b1, 8'd5);
      wait_done();
      check("ovf_next_commit", 64'(bus.commit_addr), 64'd4);
      check("ovf_next_drop_cnt", 64'(bus.drop_cnt), 64'(exp_drop));

      // Bad frame then a good frame reusing the header slot.
      reset_dut();
      send_frame(2, 4'd8, 1'b1, 1'b0, 8'd6);
      wait_done();
      check("bad_drop_cnt", 64'(bus.drop_cnt), 64'd1);
      check("bad_commit", 64'(bus.commit_addr), 64'd0);
      send_frame(2, 4'd5, 1'b0, 1'b1, 8'd7);
      wait_done();
      check("after_bad_commit", 64'(bus.commit_addr), 64'd3);

      // Wrap: commit at 14, reader at 10, header 14 and data 15, 0.
      reset_dut();
      send_frame(13, 4'd8, 1'b0, 1'b1, 8'd8);
      wait_done();
      check("pre_wrap_commit", 64'(bus.commit_addr), 64'd14);
      bus.rd_addr = 4'd10;
      send_frame(2, 4'd4, 1'b0, 1'b1, 8'd9);
      wait_done();
      check("wrap_commit", 64'(bus.commit_addr), 64'd1);
      check("wrap_drop_cnt", 64'(bus.drop_cnt), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
